// File: rtl/maple_pkg.sv
// maple_pkg: shared types and constants for the Maple bus transmitter.
// State encoding, default pulse counts and byte geometry.
package maple_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_START,
        S_DATA,
        S_END
    } state_t;

    localparam int START_PULSES_DEF = 4;
    localparam int END_PULSES_DEF   = 2;
    localparam int BITS_PER_BYTE    = 8;
    localparam int IDX_W            = $clog2(BITS_PER_BYTE);

endpackage

// File: rtl/maple_tx_if.sv
// maple_tx_if: byte stream handshake into the Maple transmitter.
// The source drives data/last/valid, the transmitter returns ready.
interface maple_tx_if;
    import maple_pkg::*;

    logic [BITS_PER_BYTE-1:0] tx_data;
    logic                     tx_last;
    logic                     tx_valid;
    logic                     tx_ready;

    modport master (
        output tx_data,
        output tx_last,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_last,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/maple_tx_shifter.sv
// maple_tx_shifter: holding register, shift register and bit index.
// Define MAPLE_TX_CRC_EN to append an XOR checksum byte to each frame.
module maple_tx_shifter
    import maple_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic             busy_nxt,
    maple_tx_if.slave        tx,
    output logic             can_load,
    output logic             bit_out,
    output logic             byte_last,
    output logic [IDX_W-1:0] bit_idx
);

    logic [BITS_PER_BYTE-1:0] hold_q, hold_d;
    logic [BITS_PER_BYTE-1:0] sh_q, sh_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic hold_full_q, hold_full_d;
    logic hold_last_q, hold_last_d;
    logic last_acc_q, last_acc_d;
    logic sh_last_q, sh_last_d;
    logic ready_d;
    logic accept;
`ifdef MAPLE_TX_CRC_EN
    logic [BITS_PER_BYTE-1:0] crc_q, crc_d;
    logic crc_due_q, crc_due_d;
`endif

    assign accept    = tx.tx_valid && tx.tx_ready;
    assign bit_out   = sh_q[BITS_PER_BYTE-1];
    assign byte_last = sh_last_q;
    assign bit_idx   = idx_q;
`ifdef MAPLE_TX_CRC_EN
    assign can_load  = hold_full_q || crc_due_q;
`else
    assign can_load  = hold_full_q;
`endif

    // Next buffer state: clear on frame start, load/shift, accept bytes.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        hold_last_d = hold_last_q;
        last_acc_d  = last_acc_q;
        sh_d        = sh_q;
        sh_last_d   = sh_last_q;
        idx_d       = idx_q;
`ifdef MAPLE_TX_CRC_EN
        crc_d       = crc_q;
        crc_due_d   = crc_due_q;
`endif
        if (clr) begin
            hold_full_d = 1'b0;
            hold_last_d = 1'b0;
            last_acc_d  = 1'b0;
            sh_last_d   = 1'b0;
`ifdef MAPLE_TX_CRC_EN
            crc_d       = '0;
            crc_due_d   = 1'b0;
`endif
        end else begin
            if (load) begin
                idx_d = IDX_W'(BITS_PER_BYTE - 1);
                if (hold_full_q) begin
                    sh_d        = hold_q;
                    hold_full_d = 1'b0;
`ifdef MAPLE_TX_CRC_EN
                    sh_last_d   = 1'b0;
                    crc_due_d   = hold_last_q;
                end else if (crc_due_q) begin
                    sh_d        = crc_q;
                    sh_last_d   = 1'b1;
                    crc_due_d   = 1'b0;
`else
                    sh_last_d   = hold_last_q;
`endif
                end
            end else if (shift) begin
                sh_d  = {sh_q[BITS_PER_BYTE-2:0], 1'b0};
                idx_d = idx_q - IDX_W'(1);
            end
            if (accept) begin
                hold_d      = tx.tx_data;
                hold_full_d = 1'b1;
                hold_last_d = tx.tx_last;
                if (tx.tx_last) last_acc_d = 1'b1;
`ifdef MAPLE_TX_CRC_EN
                crc_d       = crc_q ^ tx.tx_data;
`endif
            end
        end
    end

    // Ready is registered from the post-edge buffer state.
    assign ready_d = busy_nxt && !hold_full_d && !last_acc_d;

    // Buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            hold_last_q <= 1'b0;
            last_acc_q  <= 1'b0;
            sh_q        <= '0;
            sh_last_q   <= 1'b0;
            idx_q       <= IDX_W'(BITS_PER_BYTE - 1);
            tx.tx_ready <= 1'b0;
`ifdef MAPLE_TX_CRC_EN
            crc_q       <= '0;
            crc_due_q   <= 1'b0;
`endif
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            hold_last_q <= hold_last_d;
            last_acc_q  <= last_acc_d;
            sh_q        <= sh_d;
            sh_last_q   <= sh_last_d;
            idx_q       <= idx_d;
            tx.tx_ready <= ready_d;
`ifdef MAPLE_TX_CRC_EN
            crc_q       <= crc_d;
            crc_due_q   <= crc_due_d;
`endif
        end
    end

endmodule

// File: rtl/maple_tx.sv
// maple_tx: Maple bus frame transmitter (start, data, end patterns).
// Define MAPLE_TX_CRC_EN to append an XOR checksum byte to each frame.
module maple_tx
    import maple_pkg::*;
#(
    parameter int START_PULSES = START_PULSES_DEF,
    parameter int END_PULSES   = END_PULSES_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      tick,
    input  logic      start,
    maple_tx_if.slave tx,
    output logic      out_p1,
    output logic      out_p5,
    output logic      oe,
    output logic      busy,
    output logic      done,
    output logic      err
);

    localparam logic [7:0] START_LAST = 8'(2 * START_PULSES);
    localparam logic [7:0] END_LAST   = 8'(2 * END_PULSES + 1);
    localparam logic [7:0] END_FIN    = 8'(2 * END_PULSES + 2);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             uflag_q, uflag_d;
    logic             p1_d, p5_d, oe_d, busy_d, done_d, err_d;
    logic             sh_clr, sh_load, sh_shift;
    logic             sh_can_load, sh_bit, sh_last;
    logic [IDX_W-1:0] sh_idx;

    maple_tx_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .clr      (sh_clr),
        .load     (sh_load),
        .shift    (sh_shift),
        .busy_nxt (busy_d),
        .tx       (tx),
        .can_load (sh_can_load),
        .bit_out  (sh_bit),
        .byte_last(sh_last),
        .bit_idx  (sh_idx)
    );

    // State, phase counter and underrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            uflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            uflag_q <= uflag_d;
        end
    end

    // Next state: advance one phase per tick, schedule shifter loads.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        uflag_d  = uflag_q;
        sh_clr   = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin
                state_d = S_PRE;
                cnt_d   = '0;
                uflag_d = 1'b0;
                sh_clr  = 1'b1;
            end
            S_PRE: if (tick) begin
                state_d = S_START;
                cnt_d   = '0;
            end
            S_START: if (tick) begin
                if (cnt_q == START_LAST) begin
                    cnt_d = '0;
                    if (sh_can_load) begin
                        state_d = S_DATA;
                        sh_load = 1'b1;
                    end else begin
                        state_d = S_END;
                        uflag_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DATA: if (tick) begin
                if (cnt_q[0] && sh_idx == '0) begin
                    cnt_d = '0;
                    if (sh_last) begin
                        state_d = S_END;
                    end else if (sh_can_load) begin
                        sh_load = 1'b1;
                    end else begin
                        state_d = S_END;
                        uflag_d = 1'b1;
                    end
                end else begin
                    cnt_d    = cnt_q + 8'd1;
                    sh_shift = cnt_q[0];
                end
            end
            S_END: if (tick) begin
                if (cnt_q == END_FIN) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the phase executed on this tick.
    always_comb begin
        p1_d   = out_p1;
        p5_d   = out_p5;
        oe_d   = oe;
        busy_d = busy;
        err_d  = err;
        done_d = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin
                busy_d = 1'b1;
                err_d  = 1'b0;
            end
            S_PRE: if (tick) begin
                oe_d = 1'b1;
                p1_d = 1'b1;
                p5_d = 1'b1;
            end
            S_START: if (tick) begin
                if (cnt_q == '0) p1_d = 1'b0;
                else             p5_d = !cnt_q[0];
            end
            S_DATA: if (tick) begin
                if (sh_idx[0]) begin
                    if (!cnt_q[0]) begin
                        p5_d = 1'b1;
                        p1_d = sh_bit;
                    end else begin
                        p5_d = 1'b0;
                    end
                end else begin
                    if (!cnt_q[0]) begin
                        p1_d = 1'b1;
                        p5_d = sh_bit;
                    end else begin
                        p1_d = 1'b0;
                    end
                end
            end
            S_END: if (tick) begin
                unique case (1'b1)
                    (cnt_q == END_FIN): begin
                        oe_d   = 1'b0;
                        p1_d   = 1'b1;
                        p5_d   = 1'b1;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        err_d  = uflag_q;
                    end
                    (cnt_q == END_LAST): p5_d = 1'b1;
                    (cnt_q == '0): begin
                        p1_d = 1'b1;
                        p5_d = 1'b0;
                    end
                    default: p1_d = !cnt_q[0];
                endcase
            end
            default: ;
        endcase
    end

    // Registered line and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_p1 <= 1'b1;
            out_p5 <= 1'b1;
            oe     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            out_p1 <= p1_d;
            out_p5 <= p5_d;
            oe     <= oe_d;
            busy   <= busy_d;
            done   <= done_d;
            err    <= err_d;
        end
    end

endmodule

// File: tb/tb_maple_tx.sv
// tb_maple_tx: directed frame tests for maple_tx.
// Honours MAPLE_TX_CRC_EN for the checksum-byte expectations.
module tb_maple_tx;

    logic clk = 1'b0;
    logic rst, tick, start;
    logic out_p1, out_p5, oe, busy, done, err;

    maple_tx_if txif ();

    maple_tx dut (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .start (start),
        .tx    (txif),
        .out_p1(out_p1),
        .out_p5(out_p5),
        .oe    (oe),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int ph = 0;
    int tn = 0;
    bit start_req = 0, start_spur = 0, start_edge = 0;
    bit hs = 0;
    logic [8:0] src_q[$];
    logic [7:0] eb[$];
    bit rp1[0:127], rp5[0:127], roe[0:127];
    bit ep1[0:127], ep5[0:127], eoe[0:127];
    int et;
    int done_seen = 0, done_tn = 0;
    logic err_at_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: observe the previous edge, then drive the next one.
    task automatic step();
        @(negedge clk);
        if (tick && !start_edge) begin
            tn++;
            if (tn < 128) begin
                rp1[tn] = out_p1;
                rp5[tn] = out_p5;
                roe[tn] = oe;
            end
        end
        if (done) begin
            done_seen++;
            done_tn     = tn;
            err_at_done = err;
        end
        if (hs) void'(src_q.pop_front());
        start      = start_req;
        start_edge = start_req && !start_spur;
        if (start_edge) tn = 0;
        start_req  = 0;
        start_spur = 0;
        ph   = (ph == 2) ? 0 : ph + 1;
        tick = (ph == 0);
        if (src_q.size() > 0) begin
            txif.tx_valid = 1'b1;
            txif.tx_data  = src_q[0][7:0];
            txif.tx_last  = src_q[0][8];
        end else begin
            txif.tx_valid = 1'b0;
            txif.tx_data  = 8'h00;
            txif.tx_last  = 1'b0;
        end
        hs = txif.tx_valid && txif.tx_ready;
    endtask

    task automatic emit(input bit o, input bit a, input bit b);
        et++;
        eoe[et] = o;
        ep1[et] = a;
        ep5[et] = b;
    endtask

    // Expected per-tick line sequence for the bytes in eb.
    task automatic gen_exp();
        logic [7:0] b;
        for (int i = 0; i < 128; i++) begin
            eoe[i] = 0;
            ep1[i] = 1;
            ep5[i] = 1;
        end
        et = 0;
        emit(1, 1, 1);
        emit(1, 0, 1);
        for (int k = 0; k < 4; k++) begin
            emit(1, 0, 0);
            emit(1, 0, 1);
        end
        for (int n = 0; n < eb.size(); n++) begin
            b = eb[n];
            for (int i = 7; i >= 0; i--) begin
                if (i % 2 == 1) begin
                    emit(1, b[i], 1);
                    emit(1, b[i], 0);
                end else begin
                    emit(1, 1, b[i]);
                    emit(1, 0, b[i]);
                end
            end
        end
        emit(1, 1, 0);
        for (int k = 0; k < 2; k++) begin
            emit(1, 0, 0);
            emit(1, 1, 0);
        end
        emit(1, 1, 1);
        emit(0, 1, 1);
    endtask

    task automatic run_frame(input int budget, input bit spur);
        bit spur_done;
        spur_done = 0;
        for (int i = 0; i < 128; i++) begin
            rp1[i] = 0;
            rp5[i] = 0;
            roe[i] = 0;
        end
        done_seen = 0;
        start_req = 1;
        for (int c = 0; c < budget && done_seen == 0; c++) begin
            step();
            if (spur && !spur_done && tn == 5) begin
                start_req  = 1;
                start_spur = 1;
                spur_done  = 1;
            end
        end
        if (done_seen == 0) chk("frame_timeout", 32'd0, 32'd1);
        repeat (9) step();
    endtask

    task automatic check_frame(input string nm, input int hand_done,
                               input bit exp_err);
        for (int t = 1; t <= et + 2; t++)
            chk($sformatf("%s_t%0d_oe_p1_p5", nm, t),
                32'({roe[t], rp1[t], rp5[t]}),
                32'({eoe[t], ep1[t], ep5[t]}));
        chk({nm, "_done_tick"}, 32'(done_tn), 32'(hand_done));
        chk({nm, "_done_count"}, 32'(done_seen), 32'd1);
        chk({nm, "_err"}, 32'(err_at_done), 32'(exp_err));
        chk({nm, "_busy_after"}, 32'(busy), 32'd0);
        chk({nm, "_ready_after"}, 32'(txif.tx_ready), 32'd0);
    endtask

    function automatic logic [7:0] dec(input int k);
        logic [7:0] b;
        int t;
        for (int j = 0; j < 8; j++) begin
            t = 11 + 16 * k + 2 * j;
            b[7-j] = ((7 - j) % 2 == 1) ? rp1[t] : rp5[t];
        end
        return b;
    endfunction

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        start = 1'b0;
        txif.tx_valid = 1'b0;
        txif.tx_data = 8'h00;
        txif.tx_last = 1'b0;
        repeat (3) step();
        chk("rst_p1", 32'(out_p1), 32'd1);
        chk("rst_p5", 32'(out_p5), 32'd1);
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(txif.tx_ready), 32'd0);
        rst = 1'b0;

        src_q.push_back({1'b1, 8'h5A});
        done_seen = 0;
        repeat (60) step();
        chk("idle_p1", 32'(out_p1), 32'd1);
        chk("idle_p5", 32'(out_p5), 32'd1);
        chk("idle_oe", 32'(oe), 32'd0);
        chk("idle_ready", 32'(txif.tx_ready), 32'd0);
        chk("idle_done", 32'(done_seen), 32'd0);
        chk("idle_no_accept", 32'(src_q.size()), 32'd1);
        src_q.delete();
        step();

        src_q.push_back({1'b1, 8'hA5});
        eb.delete();
        eb.push_back(8'hA5);
`ifdef MAPLE_TX_CRC_EN
        eb.push_back(8'hA5);
`endif
        gen_exp();
        run_frame(400, 0);
`ifdef MAPLE_TX_CRC_EN
        check_frame("a5", 49, 0);
        chk("a5_crc", 32'(dec(1)), 32'hA5);
`else
        check_frame("a5", 33, 0);
`endif
        chk("a5_byte0", 32'(dec(0)), 32'hA5);

        src_q.push_back({1'b1, 8'hA5});
        run_frame(400, 1);
`ifdef MAPLE_TX_CRC_EN
        check_frame("spur", 49, 0);
`else
        check_frame("spur", 33, 0);
`endif

        src_q.push_back({1'b0, 8'h12});
        src_q.push_back({1'b1, 8'h34});
        eb.delete();
        eb.push_back(8'h12);
        eb.push_back(8'h34);
`ifdef MAPLE_TX_CRC_EN
        eb.push_back(8'h26);
`endif
        gen_exp();
        run_frame(600, 0);
`ifdef MAPLE_TX_CRC_EN
        check_frame("two", 65, 0);
        chk("two_crc", 32'(dec(2)), 32'h26);
`else
        check_frame("two", 49, 0);
`endif
        chk("two_b0", 32'(dec(0)), 32'h12);
        chk("two_b1", 32'(dec(1)), 32'h34);

        src_q.push_back({1'b0, 8'h3C});
        eb.delete();
        eb.push_back(8'h3C);
        gen_exp();
        run_frame(400, 0);
        check_frame("under", 33, 1);
        chk("under_b0", 32'(dec(0)), 32'h3C);

        src_q.push_back({1'b0, 8'h55});
        src_q.push_back({1'b1, 8'hAA});
        done_seen = 0;
        start_req = 1;
        step();
        for (int c = 0; c < 200 && tn < 14; c++) step();
        chk("mid_in_data_oe", 32'(oe), 32'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_oe", 32'(oe), 32'd0);
        chk("mid_rst_p1", 32'(out_p1), 32'd1);
        chk("mid_rst_p5", 32'(out_p5), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(txif.tx_ready), 32'd0);
        rst = 1'b0;
        src_q.delete();
        repeat (150) step();
        chk("mid_rst_no_done", 32'(done_seen), 32'd0);
        chk("mid_rst_idle_oe", 32'(oe), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
